segment_shift_driver: RTL and testbench

SEGMENT_SHIFT_DRIVER -- requirements
Module: segment_shift_driver

---
 rtl/segment_shift_driver.sv | 126 ++++++++++++
 tb/tb_segment_shift_driver.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/segment_shift_driver.sv
// Serial driver for a chain of 7-segment shift registers: shifts a NUM_DIGITS*SEG_BITS
// image out on data/clk with a programmable bit order, then pulses the latch line.
module segment_shift_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int SEG_BITS     = 8,
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 2
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_en,
  input  logic                           i_load,
  input  logic [NUM_DIGITS*SEG_BITS-1:0] i_data,
  input  logic                           i_blank,
  input  logic                           i_lsb_first,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_serial_data,
  output logic                           o_serial_clk,
  output logic                           o_serial_latch
);

  localparam int TOTAL   = NUM_DIGITS * SEG_BITS;
  localparam int BIT_W   = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int CNT_MAX = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_e;

  state_e           state_q;
  logic [TOTAL-1:0] sr_q;
  logic             lsb_first_q;
  logic [BIT_W-1:0] bit_q;
  logic [CNT_W-1:0] div_q;

  logic [TOTAL-1:0] load_img_d;
  logic [TOTAL-1:0] sr_shift_d;
  logic             first_bit_d;
  logic             next_bit_d;

  // Zero fill means the register is empty once every bit has gone out.
  always_comb begin
    load_img_d  = i_blank ? '0 : i_data;
    sr_shift_d  = lsb_first_q ? (sr_q >> 1) : (sr_q << 1);
    first_bit_d = i_lsb_first ? load_img_d[0] : load_img_d[TOTAL-1];
    next_bit_d  = lsb_first_q ? sr_shift_d[0] : sr_shift_d[TOTAL-1];
  end

  // NOTE: all state and registered outputs use <= so every register samples
  // the pre-edge values; mixing in = here would create order-dependent logic.
  always_ff @(posedge i_clk) begin
    // NOTE: reset is checked before i_en so an abort works even while frozen.
    if (i_reset) begin
      state_q        <= IDLE;
      sr_q           <= '0;
      lsb_first_q    <= 1'b0;
      bit_q          <= '0;
      div_q          <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_serial_data  <= 1'b0;
      o_serial_clk   <= 1'b0;
      o_serial_latch <= 1'b0;
    end else if (i_en) begin
      o_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_load) begin
            sr_q          <= load_img_d;
            lsb_first_q   <= i_lsb_first;
            bit_q         <= '0;
            div_q         <= '0;
            state_q       <= SHIFT_LO;
            o_busy        <= 1'b1;
            o_serial_data <= first_bit_d;
            o_serial_clk  <= 1'b0;
          end
        end
        SHIFT_LO: begin
          if (div_q == DIV_LAST) begin
            div_q        <= '0;
            state_q      <= SHIFT_HI;
            o_serial_clk <= 1'b1;
          end else begin
            div_q <= div_q + CNT_W'(1);
          end
        end
        SHIFT_HI: begin
          if (div_q == DIV_LAST) begin
            div_q        <= '0;
            sr_q         <= sr_shift_d;
            o_serial_clk <= 1'b0;
            if (bit_q == LAST_BIT) begin
              state_q        <= LATCH;
              o_serial_data  <= 1'b0;
              o_serial_latch <= 1'b1;
            end else begin
              bit_q         <= bit_q + BIT_W'(1);
              state_q       <= SHIFT_LO;
              o_serial_data <= next_bit_d;
            end
          end else begin
            div_q <= div_q + CNT_W'(1);
          end
        end
        LATCH: begin
          if (div_q == LAT_LAST) begin
            div_q          <= '0;
            state_q        <= IDLE;
            o_serial_latch <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b1;
          end else begin
            div_q <= div_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_segment_shift_driver.sv
// Randomized bench for segment_shift_driver: every cycle of each transfer is compared
// against a waveform derived from the bit sequence and the phase timing arithmetic.
module tb_segment_shift_driver;

  localparam int ND     = 4;
  localparam int SB     = 8;
  localparam int C      = 4;
  localparam int L      = 2;
  localparam int TOTAL  = ND * SB;
  localparam int SHIFT_T = 2 * C * TOTAL;
  localparam int DONE_T  = 1 + SHIFT_T + L;

  logic             i_clk = 1'b0;
  logic             i_reset, i_en, i_load, i_blank, i_lsb_first;
  logic [TOTAL-1:0] i_data;
  logic             o_busy, o_done, o_serial_data, o_serial_clk, o_serial_latch;

  int n_checks = 0;
  int n_errors = 0;

  segment_shift_driver #(
    .NUM_DIGITS(ND), .SEG_BITS(SB), .CLK_DIV(C), .LATCH_CYCLES(L)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_en(i_en), .i_load(i_load),
    .i_data(i_data), .i_blank(i_blank), .i_lsb_first(i_lsb_first),
    .o_busy(o_busy), .o_done(o_done), .o_serial_data(o_serial_data),
    .o_serial_clk(o_serial_clk), .o_serial_latch(o_serial_latch)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {o_busy, o_done, o_serial_data, o_serial_clk, o_serial_latch};
  endfunction

  // Expected {busy, done, data, clk, latch} at enabled cycle t after the load cycle.
  function automatic logic [4:0] model(input int t, input logic [TOTAL-1:0] seq);
    int p, idx;
    logic hi;
    if (t >= 1 && t <= SHIFT_T) begin
      p   = t - 1;
      idx = p / (2 * C);
      hi  = (p % (2 * C)) >= C;
      return {1'b1, 1'b0, seq[TOTAL-1-idx], hi, 1'b0};
    end
    if (t > SHIFT_T && t <= SHIFT_T + L) return 5'b10001;
    if (t == DONE_T) return 5'b01000;
    return 5'b00000;
  endfunction

  task automatic do_reset(input string tag);
    i_reset = 1'b1;
    repeat (2) begin
      i_en = 1'($urandom); i_load = 1'($urandom); i_data = $urandom;
      i_blank = 1'($urandom); i_lsb_first = 1'($urandom);
      @(negedge i_clk);
      check(tag, 32'(outs()), 32'h0);
    end
    i_reset = 1'b0; i_load = 1'b0; i_en = 1'b1;
    @(negedge i_clk);
    check({tag, ".idle"}, 32'(outs()), 32'h0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge showing o_done,
  // or after the bound expires (abort case or missing o_done).
  task automatic run_xfer(input string tag, input logic [TOTAL-1:0] data, input bit blank,
                          input bit lsb, input int reload_at, input int gap_at,
                          input int gap_len, input int rst_at);
    logic [TOTAL-1:0] img, seq, cap;
    int   t, n_cap, n_lat, done_at, limit;
    bit   aborted, prev_clk, en_edge, rst_edge;
    img = blank ? '0 : data;
    for (int i = 0; i < TOTAL; i++) seq[TOTAL-1-i] = lsb ? img[i] : img[TOTAL-1-i];
    cap = '0; n_cap = 0; n_lat = 0; done_at = -1; t = 0;
    aborted = 1'b0; prev_clk = 1'b0;
    limit = DONE_T + gap_len + 8;
    i_data = data; i_blank = blank; i_lsb_first = lsb;
    i_load = 1'b1; i_en = 1'b1; i_reset = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      en_edge  = i_en;
      rst_edge = i_reset;
      @(negedge i_clk);
      if (rst_edge) aborted = 1'b1;
      else if (en_edge && !aborted) t++;
      check($sformatf("%s.cyc%0d", tag, k), 32'(outs()), aborted ? 32'h0 : 32'(model(t, seq)));
      if (o_serial_clk && !prev_clk) begin
        cap = {cap[TOTAL-2:0], o_serial_data};
        n_cap++;
      end
      prev_clk = o_serial_clk;
      if (o_serial_latch) n_lat++;
      if (o_done && done_at < 0) done_at = k;
      if (!aborted && t == DONE_T) break;
      i_data = $urandom; i_blank = 1'($urandom); i_lsb_first = 1'($urandom);
      i_load  = aborted ? 1'b0 : 1'($urandom);
      if (k == reload_at) i_load = 1'b1;
      i_en    = !(k >= gap_at && k < gap_at + gap_len);
      i_reset = (k == rst_at);
    end
    i_load = 1'b0; i_en = 1'b1; i_reset = 1'b0;
    if (aborted) begin
      check({tag, ".abort_latch"}, 32'(n_lat), 32'h0);
      check({tag, ".abort_done"}, 32'(done_at), 32'hFFFF_FFFF);
    end else begin
      check({tag, ".word"}, 32'(cap), 32'(seq));
      check({tag, ".edges"}, 32'(n_cap), 32'(TOTAL));
      check({tag, ".latch_len"}, 32'(n_lat), 32'(L));
      check({tag, ".done_at"}, 32'(done_at), 32'(DONE_T + gap_len));
    end
  endtask

  initial begin
    logic [TOTAL-1:0] r;
    i_reset = 1'b1; i_en = 1'b0; i_load = 1'b0; i_data = '0;
    i_blank = 1'b0; i_lsb_first = 1'b0;
    do_reset("reset");

    run_xfer("msb_first", 32'hA500FF3C, 1'b0, 1'b0, -1, -1, 0, -1);
    run_xfer("lsb_first_b2b", 32'hA500FF3C, 1'b0, 1'b1, -1, -1, 0, -1);
    run_xfer("blank", 32'hFFFFFFFF, 1'b1, 1'b0, -1, -1, 0, -1);
    run_xfer("gap_reload", $urandom, 1'b0, 1'($urandom), 50, 100, 10, -1);

    // A finished transfer's o_done must survive an enable gap and ignore loads.
    i_en = 1'b0; i_load = 1'b1;
    repeat (5) begin
      @(negedge i_clk);
      check("done_hold", 32'(outs()), 32'(5'b01000));
    end
    i_load = 1'b0; i_en = 1'b1;
    @(negedge i_clk);
    check("done_release", 32'(outs()), 32'h0);

    run_xfer("reset_mid", $urandom, 1'b0, 1'b0, -1, -1, 0, 84);
    run_xfer("after_abort", 32'hA500FF3C, 1'b0, 1'b0, -1, -1, 0, -1);

    for (int n = 0; n < 3; n++) begin
      r = $urandom;
      run_xfer($sformatf("rand%0d", n), r, 1'($urandom_range(0, 3) == 0), 1'($urandom),
               $urandom_range(2, 200), $urandom_range(20, 200), $urandom_range(1, 6), -1);
    end

    do_reset("reset_end");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
